// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
// Bus widths, request bundle and ID width function.
package obi_arb_pkg;

  localparam int OBI_AW  = 32;
  localparam int OBI_DW  = 32;
  localparam int OBI_BEW = 4;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [OBI_AW-1:0]  addr;
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order ID FIFO: remembers which master owns each
// outstanding transaction.
module obi_arb_id_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wp_d  = do_push ? inc(wp_q) : wp_q;
    rp_d  = do_pop ? inc(rp_q) : rp_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      if (do_push)
        mem_q[wp_q] <= din_i;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: N masters onto one slave port,
// with lock-until-grant and in-order response routing.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 wb_rst_i,
  input  logic [NUM_MASTERS-1:0]               m_req_i,
  output logic [NUM_MASTERS-1:0]               m_gnt_o,
  input  logic [NUM_MASTERS-1:0][OBI_AW-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS-1:0][OBI_BEW-1:0]  m_be_i,
  input  logic [NUM_MASTERS-1:0][OBI_DW-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]               m_rvalid_o,
  output logic [OBI_DW-1:0]                    m_rdata_o,
  output logic                                 req_o,
  input  logic                                 gnt_i,
  output logic [OBI_AW-1:0]                    addr_o,
  output logic                                 we_o,
  output logic [OBI_BEW-1:0]                   be_o,
  output logic [OBI_DW-1:0]                    wdata_o,
  input  logic                                 rvalid_i,
  input  logic [OBI_DW-1:0]                    rdata_i,
  output logic                                 busy_o,
  output logic                                 proto_err_o
);

  localparam int IDW = id_w(NUM_MASTERS);
  localparam int CNW = $clog2(MAX_OUTSTANDING + 1);

  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] lock_idx_q, lock_idx_d;
  logic           locked_q, locked_d;
  logic           perr_q, perr_d;

  logic [IDW-1:0] rr_sel, sel, head;
  logic           any_req, hs, pop, full, empty;
  logic [CNW-1:0] count;
  obi_req_t       slv;

  // Lowest offset from rr_q wins, so scan offsets high to low.
  always_comb begin
    any_req = 1'b0;
    rr_sel  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (m_req_i[(int'(rr_q) + k) % NUM_MASTERS]) begin
        any_req = 1'b1;
        rr_sel  = IDW'((int'(rr_q) + k) % NUM_MASTERS);
      end
    end
  end

  // A locked master stays selected even if it drops req.
  assign sel   = locked_q ? lock_idx_q : rr_sel;
  assign req_o = (locked_q || any_req) && !full && !wb_rst_i;
  assign hs    = req_o && gnt_i;
  assign pop   = rvalid_i && !empty;

  always_comb begin
    slv = '0;
    if (req_o) begin
      slv.addr  = m_addr_i[sel];
      slv.we    = m_we_i[sel];
      slv.be    = m_be_i[sel];
      slv.wdata = m_wdata_i[sel];
    end
  end

  assign addr_o  = slv.addr;
  assign we_o    = slv.we;
  assign be_o    = slv.be;
  assign wdata_o = slv.wdata;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (hs)
      m_gnt_o[sel] = 1'b1;
    if (pop)
      m_rvalid_o[head] = 1'b1;
  end

  assign m_rdata_o   = rdata_i;
  assign busy_o      = (count != '0) || req_o;
  assign proto_err_o = perr_q;

  always_comb begin
    rr_d       = rr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    perr_d     = perr_q || (rvalid_i && empty);
    if (hs) begin
      locked_d = 1'b0;
      rr_d     = IDW'((int'(sel) + 1) % NUM_MASTERS);
    end else if (req_o) begin
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rr_q       <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      perr_q     <= perr_d;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (hs),
    .din_i   (sel),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed vector bench for obi_rr_arbiter (2 masters,
// 2 outstanding), plus an async-reset sequence.
module tb_obi_rr_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       m_req, m_gnt, m_we, m_rvalid;
  logic [1:0][31:0] m_addr, m_wdata;
  logic [1:0][3:0]  m_be;
  logic [31:0]      m_rdata;
  logic             req, gnt, we, rvalid, busy, perr;
  logic [31:0]      addr, wdata, rdata;
  logic [3:0]       be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obi_rr_arbiter #(
    .NUM_MASTERS     (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i       (clk),
    .wb_rst_i    (rst),
    .m_req_i     (m_req),
    .m_gnt_o     (m_gnt),
    .m_addr_i    (m_addr),
    .m_we_i      (m_we),
    .m_be_i      (m_be),
    .m_wdata_i   (m_wdata),
    .m_rvalid_o  (m_rvalid),
    .m_rdata_o   (m_rdata),
    .req_o       (req),
    .gnt_i       (gnt),
    .addr_o      (addr),
    .we_o        (we),
    .be_o        (be),
    .wdata_o     (wdata),
    .rvalid_i    (rvalid),
    .rdata_i     (rdata),
    .busy_o      (busy),
    .proto_err_o (perr)
  );

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [1:0]  e_src;
    logic        e_busy;
    logic        e_perr;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] A0 = 32'h3000_0010;
  localparam logic [31:0] A1 = 32'h3000_0020;
  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'h1111_2222;

  task automatic chk(input string n, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h",
               n, idx, act, exp);
    end
  endtask

  // Slave-side fields expected from a named source master.
  task automatic chk_slv(input int idx, input logic [1:0] src);
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    e_req = 1'b0; e_we = 1'b0; e_be = 4'h0;
    e_addr = '0;  e_wd = '0;
    if (src == 2'd0) begin
      e_req = 1'b1; e_addr = A0; e_we = 1'b0;
      e_be = 4'hF;  e_wd = D0;
    end else if (src == 2'd1) begin
      e_req = 1'b1; e_addr = A1; e_we = 1'b1;
      e_be = 4'h3;  e_wd = D1;
    end
    chk("req_o", idx, 32'(req), 32'(e_req));
    chk("addr_o", idx, addr, e_addr);
    chk("we_o", idx, 32'(we), 32'(e_we));
    chk("be_o", idx, 32'(be), 32'(e_be));
    chk("wdata_o", idx, wdata, e_wd);
  endtask

  task automatic drive(input logic [1:0] r, input logic g,
                       input logic v, input logic [31:0] d);
    m_req = r; gnt = g; rvalid = v; rdata = d;
  endtask

  initial begin
    m_addr  = '{A1, A0};
    m_wdata = '{D1, D0};
    m_be    = '{4'h3, 4'hF};
    m_we    = 2'b10;
    drive(2'b00, 1'b0, 1'b0, '0);
    rst = 1'b1;

    //          req    gnt  rv   rdata          gnt    rv     src  busy perr
    vq.push_back('{2'b00,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd3,1'b0,1'b0});
    vq.push_back('{2'b01,1'b1,1'b0,32'h0,       2'b01,2'b00,2'd0,1'b1,1'b0});
    vq.push_back('{2'b00,1'b0,1'b1,32'hDEADBEEF,2'b00,2'b01,2'd3,1'b1,1'b0});
    vq.push_back('{2'b11,1'b1,1'b0,32'h0,       2'b10,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b11,1'b1,1'b1,32'hA1,      2'b01,2'b10,2'd0,1'b1,1'b0});
    vq.push_back('{2'b11,1'b1,1'b1,32'hA0,      2'b10,2'b01,2'd1,1'b1,1'b0});
    vq.push_back('{2'b00,1'b0,1'b1,32'hA2,      2'b00,2'b10,2'd3,1'b1,1'b0});
    vq.push_back('{2'b10,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b11,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b11,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b11,1'b1,1'b0,32'h0,       2'b10,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b01,1'b1,1'b0,32'h0,       2'b01,2'b00,2'd0,1'b1,1'b0});
    vq.push_back('{2'b11,1'b1,1'b0,32'h0,       2'b00,2'b00,2'd3,1'b1,1'b0});
    vq.push_back('{2'b11,1'b1,1'b1,32'hB1,      2'b00,2'b10,2'd3,1'b1,1'b0});
    vq.push_back('{2'b11,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b11,1'b0,1'b1,32'hB0,      2'b00,2'b01,2'd1,1'b1,1'b0});
    vq.push_back('{2'b00,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b00,1'b1,1'b0,32'h0,       2'b10,2'b00,2'd1,1'b1,1'b0});
    vq.push_back('{2'b00,1'b0,1'b1,32'hC,       2'b00,2'b10,2'd3,1'b1,1'b0});
    vq.push_back('{2'b00,1'b0,1'b1,32'hE,       2'b00,2'b00,2'd3,1'b0,1'b0});
    vq.push_back('{2'b00,1'b0,1'b0,32'h0,       2'b00,2'b00,2'd3,1'b0,1'b1});
    vq.push_back('{2'b01,1'b1,1'b0,32'h0,       2'b01,2'b00,2'd0,1'b1,1'b1});
    vq.push_back('{2'b00,1'b0,1'b1,32'hD,       2'b00,2'b01,2'd3,1'b1,1'b1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].gnt, vq[i].rv, vq[i].rdata);
      #3;
      chk("m_gnt", i, 32'(m_gnt), 32'(vq[i].e_gnt));
      chk("m_rvalid", i, 32'(m_rvalid), 32'(vq[i].e_rv));
      chk("m_rdata", i, m_rdata, vq[i].rdata);
      chk("busy", i, 32'(busy), 32'(vq[i].e_busy));
      chk("perr", i, 32'(perr), 32'(vq[i].e_perr));
      chk_slv(i, vq[i].e_src);
      @(posedge clk);
      #1;
    end

    // rr_q=1 here; grant m0 so rr_q stays 1, then lock m1.
    drive(2'b01, 1'b1, 1'b0, '0);
    #3 chk("pre_gnt", 100, 32'(m_gnt), 32'h1);
    @(posedge clk); #1;
    drive(2'b10, 1'b0, 1'b0, '0);
    #3 chk_slv(101, 2'd1);
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle with one outstanding + lock.
    drive(2'b10, 1'b0, 1'b1, 32'h5);
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", 102, 32'(m_gnt), 32'h0);
    chk("rst_rvalid", 102, 32'(m_rvalid), 32'h0);
    chk("rst_busy", 102, 32'(busy), 32'h0);
    chk("rst_perr", 102, 32'(perr), 32'h0);
    chk_slv(102, 2'd3);
    @(posedge clk); #1;
    rst = 1'b0;

    drive(2'b11, 1'b1, 1'b0, '0);
    #3;
    chk("post_gnt", 103, 32'(m_gnt), 32'h1);
    chk_slv(103, 2'd0);
    @(posedge clk); #1;
    drive(2'b00, 1'b0, 1'b1, 32'h77);
    #3;
    chk("post_rvalid", 104, 32'(m_rvalid), 32'h1);
    chk("post_perr", 104, 32'(perr), 32'h0);
    @(posedge clk); #1;
    drive(2'b00, 1'b0, 1'b1, 32'h78);
    #3;
    chk("disc_rvalid", 105, 32'(m_rvalid), 32'h0);
    chk("disc_busy", 105, 32'(busy), 32'h0);
    @(posedge clk); #1;
    drive(2'b00, 1'b0, 1'b0, '0);
    #3 chk("disc_perr", 106, 32'(perr), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
